// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial pattern detector (1..MAX_LEN bits, overlap/non-overlap).
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seq_detect_prog #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pat,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_ovl,
   input  logic               sin_vld,
   input  logic               sin,
   output logic               match,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cfg_err
);
   logic [MAX_LEN-1:0] hist, hist_n, pat, mask;
   logic [LEN_W-1:0]   fill, fill_inc, len;
   logic               ovl, hit, cfg_ok;
   always_comb begin
      hist_n   = {hist[MAX_LEN-2:0], sin};
      for (int i = 0; i < MAX_LEN; i++) mask[i] = LEN_W'(i) < len;
      fill_inc = (fill >= len) ? len : fill + LEN_W'(1);
      // fill >= len-1 avoids overflow of fill+1 when MAX_LEN is 2^n-1
      hit      = sin_vld && !cfg_we && (fill >= len - LEN_W'(1)) && ((hist_n & mask) == (pat & mask));
      cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist    <= '0;
         fill    <= '0;
         pat     <= MAX_LEN'(4'b0110);
         len     <= LEN_W'(4);
         ovl     <= 1'b1;
         match   <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         match   <= hit;
         cfg_err <= cfg_we && !cfg_ok;
         if (cfg_we) begin
            if (cfg_ok) begin
               pat  <= cfg_pat;
               len  <= cfg_len;
               ovl  <= cfg_ovl;
               fill <= '0;
            end
         end else if (sin_vld) begin
            hist <= hist_n;
            fill <= (hit && !ovl) ? '0 : fill_inc;
         end
      end
   end
`ifdef SEQ_DET_CNT_EN
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else if (cfg_we && cfg_ok) cnt <= '0;
      else if (hit && cnt != '1) cnt <= cnt + CNT_W'(1);
   end
   assign match_cnt = cnt;
`else
   assign match_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: directed stimulus with a per-cycle expected-output queue checked by a monitor.
module tb_seq_detect_prog;
   logic       clk = 1'b0, rst = 1'b1;
   logic       cfg_we = 1'b0, cfg_ovl = 1'b0, sin_vld = 1'b0, sin = 1'b0;
   logic [7:0] cfg_pat = '0;
   logic [3:0] cfg_len = '0;
   logic       match, cfg_err;
   logic [1:0] match_cnt;
   logic [1:0] ecnt = '0;
   logic [3:0] exp_q[$];
   int         tests = 0, failed = 0;
`ifdef SEQ_DET_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif
   seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
      .cfg_ovl(cfg_ovl), .sin_vld(sin_vld), .sin(sin), .match(match),
      .match_cnt(match_cnt), .cfg_err(cfg_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
      tests++;
      if (got !== want) begin
         failed++;
         $display("FAIL %s {match,cnt,err} got %b exp %b at %0t", name, got, want, $time);
      end
   endtask
   // One item per clock edge; the monitor pops it #1 after that edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) chk("cycle", {match, match_cnt, cfg_err}, exp_q.pop_front());
   end
   task automatic drive(input logic we, input logic [7:0] p, input logic [3:0] l, input logic o,
                        input logic v, input logic s, input logic m, input logic e, input logic clr);
      @(negedge clk);
      cfg_we = we; cfg_pat = p; cfg_len = l; cfg_ovl = o; sin_vld = v; sin = s;
      if (clr) ecnt = '0;
      else if (m && ecnt != 2'd3) ecnt = ecnt + 2'd1;
      exp_q.push_back({m, CNT_EN ? ecnt : 2'd0, e});
   endtask
   task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic ok);
      drive(1'b1, p, l, o, 1'b0, 1'b0, 1'b0, !ok, ok);
   endtask
   task automatic send(input logic [15:0] bits, input logic [15:0] expm, input int n, input bit gap);
      for (int i = n - 1; i >= 0; i--) begin
         drive(1'b0, '0, '0, 1'b0, 1'b1, bits[i], expm[i], 1'b0, 1'b0);
         if (gap) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask
   task automatic rst_pulse();
      @(negedge clk);
      cfg_we = 1'b0; sin_vld = 1'b0; sin = 1'b0; rst = 1'b1;
      #1 chk("async_rst", {match, match_cnt, cfg_err}, 4'b0000);
      #1 rst = 1'b0;
      ecnt = '0;
   endtask
   initial begin
      repeat (2) @(negedge clk);
      chk("reset", {match, match_cnt, cfg_err}, 4'b0000);
      rst = 1'b0;
      send(16'b0110110, 16'b0001001, 7, 1'b0);
      cfg(8'h06, 4'd4, 1'b0, 1'b1);
      send(16'b0110110, 16'b0001000, 7, 1'b0);
      cfg(8'hA5, 4'd8, 1'b1, 1'b1);
      send(16'hA5, 16'h01, 8, 1'b1);
      cfg(8'h06, 4'd4, 1'b1, 1'b1);
      send(16'b0110, 16'b0001, 4, 1'b0);
      cfg(8'h03, 4'd0, 1'b0, 1'b0);
      cfg(8'h03, 4'd9, 1'b0, 1'b0);
      send(16'b0110, 16'b0001, 4, 1'b0);
      cfg(8'h01, 4'd1, 1'b1, 1'b1);
      send(16'h7F, 16'h7F, 7, 1'b0);
      cfg(8'h06, 4'd4, 1'b1, 1'b1);
      send(16'b011, 16'b000, 3, 1'b0);
      rst_pulse();
      send(16'b00110, 16'b00001, 5, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      tests++;
      if (exp_q.size() != 0) begin
         failed++;
         $display("FAIL drain %0d expected items left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
